// File: rtl/avg_pool_sched_pkg.sv
// Shared types and constants for the average-pool scheduler.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package avg_pool_sched_pkg;

    // Width of attention activations carried through the pool path.
    localparam int att_width = 16;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DRAIN,
        WAIT_END,
        WRITE,
        GAP,
        DONE
    } avg_pool_sched_state_t;

endpackage

// File: rtl/avg_pool_sched.sv
// Sequences the shared average-pool unit over an N_TOK x N_CH tile of attention outputs.
// Latency: N_TOK+4 cycles per channel (N_TOK+3 for the last) plus any pool wait, then a done pulse.
// Backpressure: none toward the buffers; the pool unit stalls the sequence by withholding pool_end.
//
// Ports: clk/rstn; start/busy/done/err toward the layer sequencer; mem_rd_en/mem_rd_addr/mem_rd_data
// token-buffer read port (data one cycle after the strobe); pool_en/pool_din/pool_end/pool_dout pool
// unit; res_we/res_addr/res_data result-buffer write port.
// Optional: define AVG_POOL_SCHED_TIMEOUT_EN to bound WAIT_END at TIMEOUT cycles; on expiry err is set
// and a zero result is written. Without it err is tied low and WAIT_END waits indefinitely.
module avg_pool_sched
    import avg_pool_sched_pkg::*;
#(
    parameter int N_TOK   = 4,
    parameter int N_CH    = 16,
    parameter int ADDR_W  = $clog2(N_TOK * N_CH),
    parameter int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic                 mem_rd_en,
    output logic [ADDR_W-1:0]    mem_rd_addr,
    input  logic [att_width-1:0] mem_rd_data,
    output logic                 pool_en,
    output logic [att_width-1:0] pool_din,
    input  logic                 pool_end,
    input  logic [att_width-1:0] pool_dout,
    output logic                 res_we,
    output logic [CH_W-1:0]      res_addr,
    output logic [att_width-1:0] res_data
);

    localparam int TOK_W = (N_TOK > 1) ? $clog2(N_TOK) : 1;

    avg_pool_sched_state_t state_q, state_d;
    logic [TOK_W-1:0]      tok_q, tok_d;
    logic [CH_W-1:0]       ch_q, ch_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  mem_rd_en_q, mem_rd_en_d;
    logic [ADDR_W-1:0]     mem_rd_addr_q, mem_rd_addr_d;
    logic                  pool_en_q, pool_en_d;
    logic                  res_we_q, res_we_d;
    logic [CH_W-1:0]       res_addr_q, res_addr_d;
    logic [att_width-1:0]  res_data_q, res_data_d;
    logic [att_width-1:0]  wr_val;

`ifdef AVG_POOL_SCHED_TIMEOUT_EN
    localparam int WT_W = $clog2(TIMEOUT + 1);
    logic [WT_W-1:0] wt_q, wt_d;
    logic            err_q, err_d;
`endif

    always_comb begin
        state_d = state_q;
        tok_d   = tok_q;
        ch_d    = ch_q;
        wr_val  = '0;
`ifdef AVG_POOL_SCHED_TIMEOUT_EN
        err_d   = err_q;
        wt_d    = '0;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FETCH;
                    ch_d    = '0;
                    tok_d   = '0;
`ifdef AVG_POOL_SCHED_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                end
            end
            FETCH: begin
                if (tok_q == TOK_W'(N_TOK - 1)) begin
                    state_d = DRAIN;
                end else begin
                    tok_d = tok_q + 1'b1;
                end
            end
            DRAIN: state_d = WAIT_END;
            WAIT_END: begin
                if (pool_end) begin
                    wr_val  = pool_dout;
                    state_d = WRITE;
                end
`ifdef AVG_POOL_SCHED_TIMEOUT_EN
                else if (wt_q == WT_W'(TIMEOUT - 1)) begin
                    // Give up on this channel: flag it and write a zero result.
                    err_d   = 1'b1;
                    state_d = WRITE;
                end else begin
                    wt_d = wt_q + 1'b1;
                end
`endif
            end
            WRITE: begin
                if (ch_q == CH_W'(N_CH - 1)) begin
                    state_d = DONE;
                end else begin
                    ch_d    = ch_q + 1'b1;
                    tok_d   = '0;
                    state_d = GAP;
                end
            end
            // One idle cycle so the pool sees pool_en fall between channels.
            GAP:     state_d = FETCH;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so they leave flops aligned with the state.
        busy_d        = (state_d != IDLE) && (state_d != DONE);
        done_d        = (state_d == DONE);
        mem_rd_en_d   = (state_d == FETCH);
        mem_rd_addr_d = mem_rd_en_d ? ADDR_W'(int'(tok_d) * N_CH + int'(ch_d)) : '0;
        // Read data lands one cycle after the strobe, so the enable follows it by one cycle.
        pool_en_d     = mem_rd_en_q;
        res_we_d      = (state_d == WRITE);
        res_addr_d    = res_we_d ? ch_d : '0;
        res_data_d    = res_we_d ? wr_val : '0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= IDLE;
            tok_q         <= '0;
            ch_q          <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            mem_rd_en_q   <= 1'b0;
            mem_rd_addr_q <= '0;
            pool_en_q     <= 1'b0;
            res_we_q      <= 1'b0;
            res_addr_q    <= '0;
            res_data_q    <= '0;
        end else begin
            state_q       <= state_d;
            tok_q         <= tok_d;
            ch_q          <= ch_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            mem_rd_en_q   <= mem_rd_en_d;
            mem_rd_addr_q <= mem_rd_addr_d;
            pool_en_q     <= pool_en_d;
            res_we_q      <= res_we_d;
            res_addr_q    <= res_addr_d;
            res_data_q    <= res_data_d;
        end
    end

`ifdef AVG_POOL_SCHED_TIMEOUT_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wt_q  <= '0;
            err_q <= 1'b0;
        end else begin
            wt_q  <= wt_d;
            err_q <= err_d;
        end
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign busy        = busy_q;
    assign done        = done_q;
    assign mem_rd_en   = mem_rd_en_q;
    assign mem_rd_addr = mem_rd_addr_q;
    assign pool_en     = pool_en_q;
    // Token buffer output is already registered; gating keeps the bus quiet outside bursts.
    assign pool_din    = pool_en_q ? mem_rd_data : '0;
    assign res_we      = res_we_q;
    assign res_addr    = res_addr_q;
    assign res_data    = res_data_q;

endmodule

// File: tb/tb_avg_pool_sched.sv
// Self-checking bench for avg_pool_sched with a token-buffer model and a floor(sum/N_TOK) pool model.
// Latency: n/a (testbench).
// Backpressure: the pool model can delay or withhold pool_end to stall the scheduler.
module tb_avg_pool_sched;
    import avg_pool_sched_pkg::*;

    localparam int N_TOK   = 4;
    localparam int N_CH    = 2;
    localparam int ADDR_W  = 3;
    localparam int CH_W    = 1;
    localparam int TIMEOUT = 8;
    localparam int W       = att_width;
    localparam int NW      = N_TOK * N_CH;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              start = 1'b0;
    logic              busy, done, err, mem_rd_en, pool_en, pool_end, res_we;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic [W-1:0]      mem_rd_data = '0;
    logic [W-1:0]      pool_din;
    logic [W-1:0]      pool_dout = '0;
    logic [CH_W-1:0]   res_addr;
    logic [W-1:0]      res_data;

    always #5 clk = ~clk;

    avg_pool_sched #(
        .N_TOK(N_TOK), .N_CH(N_CH), .ADDR_W(ADDR_W), .CH_W(CH_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rstn(rstn), .start(start), .busy(busy), .done(done), .err(err),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .pool_en(pool_en), .pool_din(pool_din), .pool_end(pool_end), .pool_dout(pool_dout),
        .res_we(res_we), .res_addr(res_addr), .res_data(res_data)
    );

    int checks = 0;
    int failures = 0;

    // Token buffer: synchronous read, data valid the cycle after the strobe.
    logic [W-1:0] mem [NW];
    always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];

    // Pool unit model: accumulate N_TOK enabled tokens, then raise pool_end after pool_delay cycles.
    int   pool_delay = 0;
    bit   pool_off = 1'b0;
    bit   spur_en = 1'b0;
    int   flush_req = 0;
    int   flush_seen = 0;
    int   pool_n = 0, pool_sum = 0, pool_cd = 0, pool_res = 0;
    bit   pool_armed = 1'b0;
    logic pool_end_m = 1'b0, pool_end_s = 1'b0;
    assign pool_end = pool_end_m | pool_end_s;

    always @(negedge clk) begin
        pool_end_m = 1'b0;
        pool_end_s = 1'b0;
        if (flush_req != flush_seen) begin
            flush_seen = flush_req;
            pool_n = 0; pool_sum = 0; pool_armed = 1'b0;
        end
        if (pool_armed) begin
            if (pool_cd == 0) begin
                pool_end_m = 1'b1;
                pool_dout  = W'(pool_res);
                pool_armed = 1'b0;
            end else begin
                pool_cd--;
            end
        end
        if (pool_en) begin
            pool_sum += int'(pool_din);
            pool_n++;
            if (pool_n == N_TOK) begin
                pool_res = pool_sum / N_TOK;
                pool_sum = 0;
                pool_n   = 0;
                if (!pool_off) begin
                    pool_armed = 1'b1;
                    pool_cd    = pool_delay;
                end
            end
        end
        // Stray end pulse with a poison value during the second read of each channel.
        if (spur_en && mem_rd_en && mem_rd_addr >= ADDR_W'(N_CH) && mem_rd_addr < ADDR_W'(2 * N_CH)) begin
            pool_end_s = 1'b1;
            pool_dout  = 16'hBEEF;
        end
    end

    // Scoreboard of expected writes and pool tokens.
    int           exp_addr[$];
    int           exp_data[$];
    logic [W-1:0] exp_din[$];

    // Observations of one tile.
    int           obs_wr_cyc[$];
    int           obs_wr_addr[$];
    int           obs_wr_data[$];
    logic [W-1:0] obs_din[$];
    int           obs_en_cyc[$];
    int           obs_done_cnt, obs_done_at, obs_busy_cnt;
    bit           obs_busy_after, obs_err_any, obs_err_first, obs_err_done;

    task automatic load_mem(input int base_a, input int base_b);
        for (int t = 0; t < N_TOK; t++) begin
            mem[t * N_CH]     = W'(base_a + t);
            mem[t * N_CH + 1] = W'(base_b + t);
        end
    endtask

    task automatic push_expected(input bit zero);
        int sum;
        exp_addr.delete(); exp_data.delete(); exp_din.delete();
        for (int c = 0; c < N_CH; c++) begin
            sum = 0;
            for (int t = 0; t < N_TOK; t++) begin
                sum += int'(mem[t * N_CH + c]);
                exp_din.push_back(mem[t * N_CH + c]);
            end
            exp_addr.push_back(c);
            exp_data.push_back(zero ? 0 : sum / N_TOK);
        end
    endtask

    // Starts a tile and records outputs each cycle; cycle 1 is the first FETCH cycle.
    task automatic run_tile(input int budget, input int restart_at);
        int cyc;
        obs_wr_cyc.delete(); obs_wr_addr.delete(); obs_wr_data.delete();
        obs_din.delete(); obs_en_cyc.delete();
        obs_done_cnt = 0; obs_done_at = -1; obs_busy_cnt = 0;
        obs_busy_after = 1'b0; obs_err_any = 1'b0; obs_err_first = 1'b0; obs_err_done = 1'b0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        cyc = 0;
        while (cyc < budget && (obs_done_at < 0 || cyc < obs_done_at + 2)) begin
            @(negedge clk);
            cyc++;
            if (pool_en) begin obs_din.push_back(pool_din); obs_en_cyc.push_back(cyc); end
            if (res_we) begin
                obs_wr_cyc.push_back(cyc);
                obs_wr_addr.push_back(int'(res_addr));
                obs_wr_data.push_back(int'(res_data));
            end
            if (done) begin
                obs_done_cnt++;
                if (obs_done_at < 0) obs_done_at = cyc;
                obs_err_done = err;
            end
            if (busy) obs_busy_cnt++;
            if (err) obs_err_any = 1'b1;
            if (cyc == 1) obs_err_first = err;
            if (obs_done_at >= 0 && cyc > obs_done_at && busy) obs_busy_after = 1'b1;
            start = (restart_at > 0 && cyc >= restart_at && cyc < restart_at + 2);
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, err, mem_rd_en, mem_rd_addr, pool_en, pool_din, res_we, res_addr, res_data} !== '0)
            begin failures++; $display("FAIL reset_outputs got=%h exp=0", {busy, done, err, mem_rd_en, mem_rd_addr, pool_en, pool_din, res_we, res_addr, res_data}); end
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, mem_rd_en, pool_en, res_we} !== '0)
            begin failures++; $display("FAIL idle_after_reset got=%b exp=00000", {busy, done, mem_rd_en, pool_en, res_we}); end
    endtask

    task automatic test_basic();
        int n;
        load_mem(1, 5);
        push_expected(1'b0);
        run_tile(200, 0);
        checks++;
        if (obs_wr_addr.size() != N_CH) begin failures++; $display("FAIL basic_wr_count got=%0d exp=%0d", obs_wr_addr.size(), N_CH); end
        n = (obs_wr_addr.size() < N_CH) ? obs_wr_addr.size() : N_CH;
        for (int i = 0; i < n; i++) begin
            checks++;
            if (obs_wr_addr[i] != exp_addr[0] || obs_wr_data[i] != exp_data[0])
                begin failures++; $display("FAIL basic_wr%0d got=(%0d,%0d) exp=(%0d,%0d)", i, obs_wr_addr[i], obs_wr_data[i], exp_addr[0], exp_data[0]); end
            checks++;
            if (obs_wr_cyc[i] != N_TOK + 3 + i * (N_TOK + 4))
                begin failures++; $display("FAIL basic_wr%0d_cycle got=%0d exp=%0d", i, obs_wr_cyc[i], N_TOK + 3 + i * (N_TOK + 4)); end
            void'(exp_addr.pop_front()); void'(exp_data.pop_front());
        end
        checks++;
        if (obs_done_cnt != 1 || obs_done_at != N_TOK + 3 + (N_CH - 1) * (N_TOK + 4) + 1)
            begin failures++; $display("FAIL basic_done got=%0d@%0d exp=1@%0d", obs_done_cnt, obs_done_at, N_TOK + 4 + (N_CH - 1) * (N_TOK + 4)); end
        checks++;
        if (obs_busy_cnt != obs_done_at - 1 || obs_busy_after)
            begin failures++; $display("FAIL basic_busy got=%0d,%0d exp=%0d,0", obs_busy_cnt, obs_busy_after, obs_done_at - 1); end
        checks++;
        if (obs_err_any) begin failures++; $display("FAIL basic_err got=1 exp=0"); end
    endtask

    task automatic test_enable_shape();
        int n, c, t;
        load_mem(1, 5);
        push_expected(1'b0);
        run_tile(200, 0);
        checks++;
        if (obs_din.size() != NW) begin failures++; $display("FAIL shape_en_count got=%0d exp=%0d", obs_din.size(), NW); end
        n = (obs_din.size() < NW) ? obs_din.size() : NW;
        for (int i = 0; i < n; i++) begin
            c = i / N_TOK;
            t = i % N_TOK;
            checks++;
            if (obs_din[i] !== exp_din[0] || obs_en_cyc[i] != 2 + t + c * (N_TOK + 4))
                begin failures++; $display("FAIL shape_tok%0d got=%0d@%0d exp=%0d@%0d", i, obs_din[i], obs_en_cyc[i], exp_din[0], 2 + t + c * (N_TOK + 4)); end
            void'(exp_din.pop_front());
        end
    endtask

    task automatic test_slow_pool();
        int n, d;
        d = 10;
        pool_delay = d;
        load_mem(1, 5);
        push_expected(1'b0);
        run_tile(300, 0);
        pool_delay = 0;
        checks++;
        if (obs_wr_addr.size() != N_CH) begin failures++; $display("FAIL slow_wr_count got=%0d exp=%0d", obs_wr_addr.size(), N_CH); end
        n = (obs_wr_addr.size() < N_CH) ? obs_wr_addr.size() : N_CH;
        for (int i = 0; i < n; i++) begin
            checks++;
            if (obs_wr_addr[i] != exp_addr[0] || obs_wr_data[i] != exp_data[0] || obs_wr_cyc[i] != N_TOK + 3 + d + i * (N_TOK + 4 + d))
                begin failures++; $display("FAIL slow_wr%0d got=(%0d,%0d)@%0d exp=(%0d,%0d)@%0d", i, obs_wr_addr[i], obs_wr_data[i], obs_wr_cyc[i], exp_addr[0], exp_data[0], N_TOK + 3 + d + i * (N_TOK + 4 + d)); end
            void'(exp_addr.pop_front()); void'(exp_data.pop_front());
        end
        checks++;
        if (obs_done_cnt != 1 || obs_busy_after) begin failures++; $display("FAIL slow_done got=%0d,%0d exp=1,0", obs_done_cnt, obs_busy_after); end
    endtask

    task automatic test_spurious();
        int n;
        spur_en = 1'b1;
        load_mem(1, 5);
        push_expected(1'b0);
        run_tile(200, 3);
        spur_en = 1'b0;
        checks++;
        if (obs_wr_addr.size() != N_CH) begin failures++; $display("FAIL spur_wr_count got=%0d exp=%0d", obs_wr_addr.size(), N_CH); end
        n = (obs_wr_addr.size() < N_CH) ? obs_wr_addr.size() : N_CH;
        for (int i = 0; i < n; i++) begin
            checks++;
            if (obs_wr_addr[i] != exp_addr[0] || obs_wr_data[i] != exp_data[0] || obs_wr_cyc[i] != N_TOK + 3 + i * (N_TOK + 4))
                begin failures++; $display("FAIL spur_wr%0d got=(%0d,%0d)@%0d exp=(%0d,%0d)@%0d", i, obs_wr_addr[i], obs_wr_data[i], obs_wr_cyc[i], exp_addr[0], exp_data[0], N_TOK + 3 + i * (N_TOK + 4)); end
            void'(exp_addr.pop_front()); void'(exp_data.pop_front());
        end
        checks++;
        if (obs_din.size() != NW) begin failures++; $display("FAIL spur_en_count got=%0d exp=%0d", obs_din.size(), NW); end
        checks++;
        if (obs_done_cnt != 1 || obs_done_at != N_TOK + 4 + (N_CH - 1) * (N_TOK + 4))
            begin failures++; $display("FAIL spur_done got=%0d@%0d exp=1@%0d", obs_done_cnt, obs_done_at, N_TOK + 4 + (N_CH - 1) * (N_TOK + 4)); end
    endtask

    task automatic test_reset_mid();
        bit bad;
        int n;
        load_mem(1, 5);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (N_TOK + 6) @(negedge clk);
        checks++;
        if (mem_rd_en !== 1'b1 || mem_rd_addr !== ADDR_W'(N_CH + 1))
            begin failures++; $display("FAIL midop_fetch got=%b,%0d exp=1,%0d", mem_rd_en, mem_rd_addr, N_CH + 1); end
        #2 rstn = 1'b0;
        #1;
        checks++;
        if ({busy, done, err, mem_rd_en, mem_rd_addr, pool_en, pool_din, res_we, res_addr, res_data} !== '0)
            begin failures++; $display("FAIL midop_reset_outputs got=%h exp=0", {busy, done, err, mem_rd_en, mem_rd_addr, pool_en, pool_din, res_we, res_addr, res_data}); end
        flush_req++;
        bad = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (done || res_we || busy) bad = 1'b1;
        end
        rstn = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (done || res_we || busy) bad = 1'b1;
        end
        checks++;
        if (bad) begin failures++; $display("FAIL midop_abort got=activity exp=quiet"); end
        load_mem(100, 7);
        mem[NW - 1] = W'(12);
        push_expected(1'b0);
        run_tile(200, 0);
        checks++;
        if (obs_wr_addr.size() != N_CH || obs_done_cnt != 1)
            begin failures++; $display("FAIL midop_new_tile got=%0d,%0d exp=%0d,1", obs_wr_addr.size(), obs_done_cnt, N_CH); end
        n = (obs_wr_addr.size() < N_CH) ? obs_wr_addr.size() : N_CH;
        for (int i = 0; i < n; i++) begin
            checks++;
            if (obs_wr_addr[i] != exp_addr[0] || obs_wr_data[i] != exp_data[0])
                begin failures++; $display("FAIL midop_wr%0d got=(%0d,%0d) exp=(%0d,%0d)", i, obs_wr_addr[i], obs_wr_data[i], exp_addr[0], exp_data[0]); end
            void'(exp_addr.pop_front()); void'(exp_data.pop_front());
        end
    endtask

`ifdef AVG_POOL_SCHED_TIMEOUT_EN
    task automatic test_timeout();
        int n, d;
        d = TIMEOUT - 1;
        pool_off = 1'b1;
        load_mem(1, 5);
        push_expected(1'b1);
        run_tile(400, 0);
        pool_off = 1'b0;
        checks++;
        if (obs_wr_addr.size() != N_CH) begin failures++; $display("FAIL to_wr_count got=%0d exp=%0d", obs_wr_addr.size(), N_CH); end
        n = (obs_wr_addr.size() < N_CH) ? obs_wr_addr.size() : N_CH;
        for (int i = 0; i < n; i++) begin
            checks++;
            if (obs_wr_addr[i] != exp_addr[0] || obs_wr_data[i] != exp_data[0] || obs_wr_cyc[i] != N_TOK + 3 + d + i * (N_TOK + 4 + d))
                begin failures++; $display("FAIL to_wr%0d got=(%0d,%0d)@%0d exp=(%0d,%0d)@%0d", i, obs_wr_addr[i], obs_wr_data[i], obs_wr_cyc[i], exp_addr[0], exp_data[0], N_TOK + 3 + d + i * (N_TOK + 4 + d)); end
            void'(exp_addr.pop_front()); void'(exp_data.pop_front());
        end
        checks++;
        if (obs_done_cnt != 1 || obs_err_done !== 1'b1) begin failures++; $display("FAIL to_done_err got=%0d,%b exp=1,1", obs_done_cnt, obs_err_done); end
        checks++;
        if (err !== 1'b1) begin failures++; $display("FAIL to_err_sticky got=%b exp=1", err); end
        flush_req++;
        load_mem(1, 5);
        push_expected(1'b0);
        run_tile(200, 0);
        checks++;
        if (obs_err_first !== 1'b0 || obs_err_any) begin failures++; $display("FAIL to_err_clear got=%b,%b exp=0,0", obs_err_first, obs_err_any); end
        checks++;
        if (obs_wr_data.size() != N_CH || obs_wr_data[0] != exp_data[0] || obs_wr_data[N_CH - 1] != exp_data[N_CH - 1])
            begin failures++; $display("FAIL to_recover got=%0d writes exp=%0d with pooled data", obs_wr_data.size(), N_CH); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_enable_shape();
        test_slow_pool();
        test_spurious();
        test_reset_mid();
`ifdef AVG_POOL_SCHED_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/avg_pool_sched.md
Name: avg_pool_sched

Overview:
- Controller that sequences the shared average-pooling datapath over a tile of attention outputs.
- For each channel it streams N_TOK tokens from the token buffer into the pool unit, waits for the pool's end flag, and writes the pooled value to a result buffer.
- Sits between the attention output buffer and the classifier-head input buffer.
- Uses a start/busy/done handshake toward the layer sequencer.

Parameters:
- N_TOK, 4, tokens per channel; equals the pool unit's window depth.
- N_CH, 16, channels per tile.
- ADDR_W, $clog2(N_TOK*N_CH), token-buffer address width.
- CH_W, $clog2(N_CH) (min 1), result-buffer address width.
- TIMEOUT, 64, max WAIT_END cycles; used only with the optional feature.

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- start  in  1  begin a tile; sampled only in IDLE.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when the tile is complete.
- err  out  1  sticky timeout flag, cleared on start.
- mem_rd_en  out  1  token-buffer read strobe.
- mem_rd_addr  out  ADDR_W  read address = tok*N_CH + ch.
- mem_rd_data  in  att_width  read data, valid exactly 1 cycle after mem_rd_en.
- pool_en  out  1  pool-unit enable.
- pool_din  out  att_width  token into pool unit.
- pool_end  in  1  pool result valid.
- pool_dout  in  att_width  pooled value.
- res_we  out  1  result-buffer write strobe.
- res_addr  out  CH_W  result address = ch.
- res_data  out  att_width  result data.

Behaviour:
- Reset (rstn low, asynchronous): state IDLE; all outputs 0; ch and tok counters 0; err 0. Reset mid-tile aborts with no done and no write.
- All outputs are registered.
- States:
  - IDLE: start=1 -> FETCH, ch=0, tok=0, err=0. start while not in IDLE is ignored.
  - FETCH: mem_rd_en=1, mem_rd_addr=tok*N_CH+ch; tok increments each cycle. After N_TOK reads -> DRAIN.
  - DRAIN: one cycle; the last read's data reaches the pool -> WAIT_END.
  - WAIT_END: hold until pool_end=1, then capture pool_dout -> WRITE.
  - WRITE: res_we=1 for one cycle with res_addr=ch and res_data=captured value. If ch==N_CH-1 -> DONE; else ch++, tok=0 -> GAP.
  - GAP: one cycle with pool_en=0 so the pool sees a fresh enable edge -> FETCH.
  - DONE: done=1 for one cycle, busy=0 -> IDLE.
- Pool interface:
  - pool_en is mem_rd_en delayed 1 cycle; pool_din = mem_rd_data.
  - pool_en is high exactly N_TOK consecutive cycles per channel, contiguous, never across channels.
- pool_end is ignored outside WAIT_END.
- Timing per channel when pool_end is high on the first WAIT_END cycle:
  - Channels 0..N_CH-2: N_TOK+4 cycles (FETCH N_TOK, DRAIN, WAIT_END, WRITE, GAP).
  - Last channel: N_TOK+3 cycles plus the DONE cycle.
- No arithmetic in this block; data passes through at att_width.
- Counters wrap only via explicit reset to 0, never by overflow.

Optional Feature:
- Macro: AVG_POOL_SCHED_TIMEOUT_EN.
- Defined:
  - A WAIT_END cycle counter runs per channel.
  - If TIMEOUT cycles pass without pool_end: set err, write 0 to res_addr=ch, and continue normally (GAP or DONE).
  - A late pool_end is then ignored.
- Undefined: no counter; err is tied 0; WAIT_END waits indefinitely.

Decomposition:
- Package definition: att_width (existing); add typedef enum avg_pool_sched_state_t {IDLE, FETCH, DRAIN, WAIT_END, WRITE, GAP, DONE}.
- No sub-module; counters and the FSM live in one module.

Test Plan (N_TOK=4, N_CH=2, pool reference model = floor(sum/4)):
- Basic tile:
  - Stimulus: buffer addr 0,2,4,6 = 1,2,3,4; addr 1,3,5,7 = 5,6,7,8; start pulse.
  - Required: res writes (0,2) then (1,6); done once; busy low after.
- Enable shape:
  - Stimulus: same tile.
  - Required: pool_en high exactly 4 consecutive cycles per channel with din 1,2,3,4 then 5,6,7,8; at least 1 low cycle between the two bursts.
- Slow pool:
  - Stimulus: pool_end delayed 10 cycles.
  - Required: controller holds in WAIT_END; no res_we before pool_end; result values unchanged.
- Spurious inputs:
  - Stimulus: pool_end pulsed during FETCH; start re-asserted while busy.
  - Required: both ignored; sequence and results identical to the basic tile.
- Reset mid-op:
  - Stimulus: rstn low during channel 1 FETCH, then start again.
  - Required: all outputs 0 immediately; no done for the aborted tile; the new tile completes correctly.
- Timeout (AVG_POOL_SCHED_TIMEOUT_EN, TIMEOUT=8):
  - Stimulus: pool_end never asserted.
  - Required: err=1; res writes (0,0),(1,0); done pulse; err cleared by the next start.
